// File: rtl/jtag_dp_access_reg.sv
// JDPACC data register: captures status and last read data, shifts TDI->TDO,
// and on Update-DR launches one debug-port bus transaction via req/ack.
module jtag_dp_access_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tdi,
    input  logic                  state_test_logic_reset,
    input  logic                  state_capture_dr,
    input  logic                  state_shift_dr,
    input  logic                  state_update_dr,
    input  logic                  insn_jdpacc_select,
    output logic                  jdpacc_tdo,
    output logic                  dp_req,
    output logic                  dp_wr,
    output logic [ADDR_WIDTH-1:0] dp_addr,
    output logic [DATA_WIDTH-1:0] dp_wdata,
    input  logic                  dp_ack,
    input  logic                  dp_err,
    input  logic [DATA_WIDTH-1:0] dp_rdata
);

    localparam int SRW = DATA_WIDTH + ADDR_WIDTH + 1;

    localparam logic [2:0] STATUS_WAIT  = 3'b001;
    localparam logic [2:0] STATUS_OK    = 3'b010;
    localparam logic [2:0] STATUS_FAULT = 3'b100;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [SRW-1:0]          sr;
    logic [SRW-1:0]          capture_val;
    logic [2:0]              status;
    logic                    sticky_err;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    upd_rnw;
    logic [ADDR_WIDTH-1:0]   upd_addr;
    logic [DATA_WIDTH-1:0]   upd_data;
    logic                    do_capture;
    logic                    do_shift;
    logic                    do_update;
    logic                    local_clear;
    logic                    clear_req;
    logic                    launch;
    logic                    done;

    assign upd_rnw  = sr[0];
    assign upd_addr = sr[ADDR_WIDTH:1];
    assign upd_data = sr[SRW-1:ADDR_WIDTH+1];

    assign do_capture = insn_jdpacc_select & state_capture_dr;
    assign do_shift   = insn_jdpacc_select & state_shift_dr;
    assign do_update  = insn_jdpacc_select & state_update_dr;

    // A write of 1 to address 0 is consumed locally to clear the sticky error.
    assign local_clear = ~upd_rnw & (upd_addr == '0) & upd_data[0];
    assign clear_req   = do_update & (state_q == IDLE) & local_clear;
    assign launch      = do_update & (state_q == IDLE) & ~local_clear & ~sticky_err;
    assign done        = (state_q == BUSY) & dp_ack;

    assign jdpacc_tdo = sr[0];

    // FSM state register
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; Test-Logic-Reset intentionally does not abort BUSY
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = BUSY;
            BUSY:    if (dp_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        dp_req = (state_q == BUSY);
    end

    always_comb begin
        if (state_q == BUSY) begin
            status = STATUS_WAIT;
        end else if (sticky_err) begin
            status = STATUS_FAULT;
        end else begin
            status = STATUS_OK;
        end
    end

    always_comb begin
        capture_val                        = '0;
        capture_val[2:0]                   = status;
        capture_val[SRW-1 -: DATA_WIDTH]   = rdata_q;
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            sr <= '0;
        end else if (state_test_logic_reset) begin
            sr <= '0;
        end else if (do_capture) begin
            sr <= capture_val;
        end else if (do_shift) begin
            sr <= {tdi, sr[SRW-1:1]};
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            sticky_err <= 1'b0;
        end else if (state_test_logic_reset || clear_req) begin
            sticky_err <= 1'b0;
        end else if (done && dp_err) begin
            sticky_err <= 1'b1;
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            rdata_q <= '0;
        end else if (done && !dp_err && !dp_wr) begin
            rdata_q <= dp_rdata;
        end
    end

    // Bus command fields are held after completion until the next launch.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            dp_wr    <= 1'b0;
            dp_addr  <= '0;
            dp_wdata <= '0;
        end else if (launch) begin
            dp_wr    <= ~upd_rnw;
            dp_addr  <= upd_addr;
            dp_wdata <= upd_data;
        end
    end

endmodule

// File: doc/jtag_dp_access_reg.md
Name: jtag_dp_access_reg

Overview:
- JDPACC data register behind the JTAG TAP.
- Captures transaction status and last read data, then shifts TDI→TDO while the JDPACC instruction is selected.
- On Update-DR it launches one read/write on the debug-port bus through a req/ack handshake.
- Its serial output is the jdpacc_tdo input the TAP's data-register mux consumes.

Parameters:
- DATA_WIDTH, 32: debug-port bus data width.
- ADDR_WIDTH, 2: debug-port register address width.

Ports:
- tck  input  1  test clock; all logic rises on posedge.
- trst  input  1  asynchronous active-low reset.
- tdi  input  1  test data in.
- state_test_logic_reset  input  1  TAP FSM in Test-Logic-Reset.
- state_capture_dr  input  1  TAP FSM in Capture-DR.
- state_shift_dr  input  1  TAP FSM in Shift-DR.
- state_update_dr  input  1  TAP FSM in Update-DR.
- insn_jdpacc_select  input  1  JDPACC instruction latched in IR.
- jdpacc_tdo  output  1  serial out to the TAP; equals sr[0].
- dp_req  output  1  bus request, held until acknowledged.
- dp_wr  output  1  1=write, 0=read; stable while dp_req.
- dp_addr  output  ADDR_WIDTH  register address; stable while dp_req.
- dp_wdata  output  DATA_WIDTH  write data; stable while dp_req.
- dp_ack  input  1  one-cycle completion pulse.
- dp_err  input  1  error flag, valid with dp_ack.
- dp_rdata  input  DATA_WIDTH  read data, valid with dp_ack.

Behaviour:
- Shift register sr, SRW = DATA_WIDTH+ADDR_WIDTH+1 bits (35 by default).
  - Update fields: sr[0]=RnW, sr[ADDR_WIDTH:1]=addr, sr[SRW-1:ADDR_WIDTH+1]=data.
  - Capture fields: sr[2:0]=status, upper DATA_WIDTH bits=rdata_q.
- Internal state: sticky_err (1b), rdata_q (DATA_WIDTH), FSM {IDLE, BUSY}.
- Reset (trst=0, async): sr=0, rdata_q=0, sticky_err=0, FSM=IDLE, dp_req=0, dp_wr=0, dp_addr=0, dp_wdata=0, jdpacc_tdo=0.
- state_test_logic_reset (sync):
  - clears sr and sticky_err.
  - does NOT abort an outstanding request; BUSY completes normally.
- All capture/shift/update actions require insn_jdpacc_select=1; otherwise sr holds and no request is launched.
- Capture-DR:
  - Status is computed from pre-edge state, priority BUSY → 3'b001 WAIT, sticky_err → 3'b100 FAULT, else 3'b010 OK.
  - Data field = rdata_q.
- Shift-DR: sr <= {tdi, sr[SRW-1:1]}. LSB first out, one bit per tck.
- Update-DR, FSM=BUSY (pre-edge): ignored, no state change. Includes the edge where dp_ack arrives.
- Update-DR, FSM=IDLE, local clear:
  - Applies when RnW=0, addr=0, data[0]=1.
  - sticky_err <= 0; no bus request.
- Update-DR, FSM=IDLE, sticky_err=1 and not a local clear: ignored.
- Update-DR, FSM=IDLE, otherwise:
  - latch dp_wr = ~RnW, dp_addr, dp_wdata = data field.
  - dp_req <= 1; FSM → BUSY.
  - dp_req rises the edge after Update-DR.
- BUSY, dp_ack=1: next edge dp_req <= 0 and FSM → IDLE.
  - If dp_err=1: sticky_err <= 1; rdata_q unchanged.
  - Else if read: rdata_q <= dp_rdata.
  - Write with no error: rdata_q unchanged.
- dp_ack while IDLE: ignored.
- Only one transaction outstanding; there is no queue.
- Simultaneous dp_ack and Capture-DR: capture reports WAIT; the next capture reports the result.
- dp_wr, dp_addr, dp_wdata hold their last values after completion.

Test Plan:
- Reset with trst=0 mid-BUSY → dp_req=0 asynchronously, FSM IDLE; next capture shifts out status 010, data 0.
- Write: shift 35 bits (RnW=0, addr=1, data=0xDEADBEEF), Update → next edge dp_req=1, dp_wr=1, dp_addr=1, dp_wdata=0xDEADBEEF. Ack 3 cycles later → dp_req=0 the following edge.
- Read: RnW=1, addr=2; ack with dp_rdata=0x12345678. Capture+shift → first 3 bits 0,1,0 (OK), next 32 bits 0x12345678 LSB first.
- Capture while BUSY (ack withheld) → status 001. Second Update while BUSY → no new dp_req edge and dp_addr unchanged.
- Ack with dp_err=1 → capture status 100; a normal read Update is ignored (dp_req stays 0). Local clear (RnW=0, addr=0, data=1) → status 010 and no dp_req.
- insn_jdpacc_select=0 during capture/shift/update → sr and jdpacc_tdo unchanged, dp_req stays 0.
